// File: rtl/rot_normalizer.sv
// Sequential rotate-normalizer: rotates a word left one bit per cycle until the MSB is set,
// reporting the normalized word, the rotation (leading-zero) count and a zero-operand flag.
module rot_normalizer #(
  parameter int WIDTH = 16,
  parameter int CW    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_in,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_out,
  output logic [CW-1:0]    o_count,
  output logic             o_zero
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  state_t           w_nextState;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_nextShift;
  logic [CW-1:0]    r_count;
  logic [CW-1:0]    w_nextCount;
  logic             r_zero;
  logic             w_nextZero;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_count <= '0;
      r_zero  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_shift <= w_nextShift;
      r_count <= w_nextCount;
      r_zero  <= w_nextZero;
    end
  end

  // Results hold in IDLE so software can read them after the done pulse.
  always_comb begin
    w_nextState = r_state;
    w_nextShift = r_shift;
    w_nextCount = r_count;
    w_nextZero  = r_zero;
    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_nextShift = i_in;
          w_nextCount = '0;
          if (i_in == '0) begin
            w_nextZero  = 1'b1;
            w_nextState = DONE;
          end else begin
            w_nextZero  = 1'b0;
            w_nextState = RUN;
          end
        end
      end
      RUN: begin
        if (r_shift[WIDTH-1]) begin
          w_nextState = DONE;
        end else begin
          w_nextShift = {r_shift[WIDTH-2:0], r_shift[WIDTH-1]};
          w_nextCount = r_count + CW'(1);
        end
      end
      DONE: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  assign o_busy  = (r_state != IDLE);
  assign o_done  = (r_state == DONE);
  assign o_out   = r_shift;
  assign o_count = r_count;
  assign o_zero  = r_zero;

endmodule

// File: tb/tb_rot_normalizer.sv
// Scoreboard bench for rot_normalizer: a driver queues expected results from a
// leading-zero reference model and a negedge monitor checks every done pulse against them.
module tb_rot_normalizer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] inWord;
  logic        busy;
  logic        done;
  logic [15:0] outWord;
  logic [3:0]  count;
  logic        zero;

  typedef struct {
    logic [15:0] op;
    logic [15:0] out;
    int          cnt;
    bit          z;
    int          doneEdge;
    int          busyLen;
  } exp_t;

  exp_t        sb[$];
  int          vectors = 0;
  int          miscompares = 0;
  int          edgeCnt = 0;
  int          busyRun = 0;
  logic [15:0] lastOut = '0;
  int          lastCnt = 0;
  bit          lastZero = 1'b0;

  rot_normalizer #(.WIDTH(16), .CW(4)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_in    (inWord),
    .o_busy  (busy),
    .o_done  (done),
    .o_out   (outWord),
    .o_count (count),
    .o_zero  (zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) edgeCnt++;

  task automatic checkOutput(input string name, input int act, input int exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: normalizing means rotating left by the number of leading zeros.
  function automatic exp_t model(input logic [15:0] op);
    exp_t e;
    int   lz;
    int   w;
    e.op = op;
    if (op == 16'h0000) begin
      e.out = 16'h0000;
      e.cnt = 0;
      e.z   = 1'b1;
    end else begin
      lz = 0;
      while (op[15-lz] == 1'b0) lz++;
      w     = int'(op);
      e.out = 16'(((w << lz) | (w >> (16 - lz))) & 32'hFFFF);
      e.cnt = lz;
      e.z   = 1'b0;
    end
    e.doneEdge = 0;
    e.busyLen  = e.z ? 1 : e.cnt + 2;
    return e;
  endfunction

  function automatic logic [15:0] rotRight(input logic [15:0] w, input int n);
    int x;
    x = int'(w);
    return 16'(((x >> n) | (x << (16 - n))) & 32'hFFFF);
  endfunction

  // Monitor: pops one expectation per done pulse; in idle the last result must hold.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy) busyRun++;
      else busyRun = 0;
      if (done) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_done", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          checkOutput("out", int'(outWord), int'(e.out));
          checkOutput("count", int'(count), e.cnt);
          checkOutput("zero", int'(zero), int'(e.z));
          checkOutput("done_edge", edgeCnt, e.doneEdge);
          checkOutput("busy_len", busyRun, e.busyLen);
          checkOutput("rotr_restore", int'(rotRight(outWord, int'(count))), int'(e.op));
          lastOut  = e.out;
          lastCnt  = e.cnt;
          lastZero = e.z;
        end
      end else if (!busy) begin
        checkOutput("idle_hold_out", int'(outWord), int'(lastOut));
        checkOutput("idle_hold_count", int'(count), lastCnt);
        checkOutput("idle_hold_zero", int'(zero), int'(lastZero));
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] op, input bit noise);
    exp_t e;
    int   t;
    @(negedge clk);
    t = 0;
    while (busy && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (busy) begin
      checkOutput("idle_timeout", 1, 0);
      return;
    end
    start  = 1'b1;
    inWord = op;
    @(posedge clk);
    #1;
    e = model(op);
    e.doneEdge = e.z ? edgeCnt : edgeCnt + e.cnt + 1;
    sb.push_back(e);
    @(negedge clk);
    t = 0;
    while (busy && t < 50) begin
      if (noise) begin
        start  = 1'($urandom_range(0, 1));
        inWord = 16'($urandom);
      end else begin
        start  = 1'b0;
        inWord = 16'($urandom);
      end
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (busy) checkOutput("done_timeout", 1, 0);
  endtask

  task automatic applyResetMidRun();
    @(negedge clk);
    start  = 1'b1;
    inWord = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    lastOut  = '0;
    lastCnt  = 0;
    lastZero = 1'b0;
    #1;
    checkOutput("rst_mid_out", int'(outWord), 0);
    checkOutput("rst_mid_count", int'(count), 0);
    checkOutput("rst_mid_zero", int'(zero), 0);
    checkOutput("rst_mid_busy", int'(busy), 0);
    checkOutput("rst_mid_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  initial begin
    int t;
    rst    = 1'b1;
    start  = 1'b0;
    inWord = 16'h0000;
    #3;
    checkOutput("reset_out", int'(outWord), 0);
    checkOutput("reset_count", int'(count), 0);
    checkOutput("reset_zero", int'(zero), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_done", int'(done), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(16'h8000, 1'b0);
    applyStimulus(16'h0001, 1'b0);
    applyStimulus(16'h00F3, 1'b0);
    applyStimulus(16'h1234, 1'b0);
    applyStimulus(16'h0000, 1'b0);
    applyStimulus(16'h4000, 1'b0);
    applyStimulus(16'h0004, 1'b1);
    applyResetMidRun();
    applyStimulus(16'h0003, 1'b0);

    for (int i = 0; i < 150; i++) begin
      logic [15:0] op;
      case ($urandom_range(0, 9))
        0:       op = 16'h0000;
        1:       op = 16'h0001 << $urandom_range(0, 15);
        default: op = 16'($urandom) >> $urandom_range(0, 15);
      endcase
      applyStimulus(op, 1'($urandom_range(0, 1)));
    end

    t = 0;
    while ((sb.size() != 0 || busy) && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) checkOutput("drain_timeout", sb.size(), 0);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
